sp_ram_arbiter: RTL and testbench
=================================

// Module: sp_ram_arbiter
// PURPOSE
//  Shares one byte-write single-port RAM (1-cycle registered read, byte enables) between two
//  requesters (e.g. core LSU p0, DMA/debug p1). Round-robin grant, one access per cycle,
//  per-port response valid one cycle after grant. Optional post-reset RAM zero-fill sequencer.
// PARAMETERS
//  ADDR_WIDTH  8                RAM word-address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32               word width, multiple of 8
//  NUM_BYTE    DATA_WIDTH/8     byte-enable width
//  INIT_VALUE  '0               word written by init sequencer (SP_RAM_ARB_INIT_EN only)
// PORTS
//  clk_i          in   1           clock, all state on rising edge
//  rst_i          in   1           asynchronous reset, active high
//  pN_req_i       in   1           N=0,1: access request, held until pN_gnt_o
//  pN_we_i        in   1           1=write, 0=read
//  pN_addr_i      in   ADDR_WIDTH  word address
//  pN_wdata_i     in   DATA_WIDTH  write data
//  pN_be_i        in   NUM_BYTE    byte enables (writes only)
//  pN_gnt_o       out  1           request accepted this cycle (combinational)
//  pN_rvalid_o    out  1           response for the access granted last cycle
//  pN_rdata_o     out  DATA_WIDTH  read data, meaningful when pN_rvalid_o for a read
//  ram_en_o       out  1           RAM enable
//  ram_we_o       out  1           RAM write enable
//  ram_addr_o     out  ADDR_WIDTH  RAM address
//  ram_wdata_o    out  DATA_WIDTH  RAM write data
//  ram_be_o       out  NUM_BYTE    RAM byte enables
//  ram_rdata_i    in   DATA_WIDTH  RAM read data (valid 1 cycle after read enable)
//  init_done_o    out  1           1 = arbiter serving requesters
// BEHAVIOUR
//  - Reset: pN_gnt_o=0, pN_rvalid_o=0, ram_en_o=0, rr pointer favours p0, pending response cleared.
//  - FSM: INIT (feature only) -> ARB. ARB is the terminal state until reset.
//  - ARB: grant is combinational from req in the same cycle; at most one gnt per cycle.
//    Only p0 req -> p0; only p1 -> p1; both -> port not granted last (rr pointer), pointer
//    updates only on a grant. Idle cycles leave pointer unchanged.
//  - Granted port's we/addr/wdata/be muxed to ram_* with ram_en_o=1; no grant -> ram_en_o=0,
//    ram_we_o=0, other ram_* don't-care.
//  - Response reg: captures {port, is_read} on grant; next cycle pN_rvalid_o=1 for that port only,
//    for reads and writes (write ack). Latency gnt->rvalid = exactly 1 cycle, back-to-back
//    grants every cycle allowed (full throughput).
//  - pN_rdata_o = ram_rdata_i (shared); requester samples only with rvalid of a read.
//  - Write ordering: write granted in cycle T, read of same address granted T+1 returns new data.
//  - Reset mid-operation: in-flight response dropped (no rvalid after reset), any RAM write
//    issued in the reset cycle is not guaranteed.
//  - Requester may drop req without gnt; no state retained for ungranted requests.
// CONFIGURATION
//  SP_RAM_ARB_INIT_EN defined:
//   - After reset release FSM in INIT: writes INIT_VALUE, be all ones, addr 0..2**ADDR_WIDTH-1,
//     one word per cycle; pN_gnt_o=0, pN_rvalid_o=0, init_done_o=0 throughout.
//   - Cycle after last address (wrap of counter) -> ARB, init_done_o=1.
//   - Reset during INIT restarts at address 0.
//  Not defined: no INIT state or counter; init_done_o=1 whenever rst_i=0; ARB directly after reset.
// TESTING
//  - p0 read addr 0x10 alone -> p0_gnt same cycle, p0_rvalid next cycle, p0_rdata=RAM[0x10].
//  - p0 write 0xDEADBEEF be=4'b0101 @0x20, then p1 read @0x20 -> p1_rdata=old data with bytes
//    0,2 = 0xEF,0xAD; p0_rvalid 1 cycle after write gnt.
//  - p0,p1 req every cycle for 8 cycles after reset -> gnt p0,p1,p0,p1..., 8 rvalids, no gaps.
//  - p1 only for 3 cycles then both -> p1,p1,p1 then p0 wins tie.
//  - Assert rst_i 1 cycle after gnt -> no rvalid follows; post-reset tie grants p0.
//  - INIT_EN, ADDR_WIDTH=4: init_done_o rises 16 cycles after reset, reqs ungranted before;
//    all 16 words read back INIT_VALUE; reset at cycle 5 -> restarts, done 16 cycles later.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Round-robin two-requester front end for a byte-write single-port RAM.
// Define SP_RAM_ARB_INIT_EN to fill the RAM with INIT_VALUE after reset.
module sp_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_BYTE = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  p0_req_i,
   input  logic                  p0_we_i,
   input  logic [ADDR_WIDTH-1:0] p0_addr_i,
   input  logic [DATA_WIDTH-1:0] p0_wdata_i,
   input  logic [NUM_BYTE-1:0]   p0_be_i,
   output logic                  p0_gnt_o,
   output logic                  p0_rvalid_o,
   output logic [DATA_WIDTH-1:0] p0_rdata_o,
   input  logic                  p1_req_i,
   input  logic                  p1_we_i,
   input  logic [ADDR_WIDTH-1:0] p1_addr_i,
   input  logic [DATA_WIDTH-1:0] p1_wdata_i,
   input  logic [NUM_BYTE-1:0]   p1_be_i,
   output logic                  p1_gnt_o,
   output logic                  p1_rvalid_o,
   output logic [DATA_WIDTH-1:0] p1_rdata_o,
   output logic                  ram_en_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic [NUM_BYTE-1:0]   ram_be_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  init_done_o
);

   logic prio_q, prio_d;
   logic rv0_q, rv0_d;
   logic rv1_q, rv1_d;
   logic active;
   logic init_wr;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic g0, g1;

`ifdef SP_RAM_ARB_INIT_EN
   typedef enum logic {ST_INIT, ST_ARB} state_e;
   state_e state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      done_d = done_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (&cnt_q) begin
            state_d = ST_ARB;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         cnt_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
      end
   end

   assign active = done_q & ~rst_i;
   assign init_wr = (state_q == ST_INIT) & ~rst_i;
   assign init_addr = cnt_q;
   assign init_done_o = done_q;
`else
   assign active = ~rst_i;
   assign init_wr = 1'b0;
   assign init_addr = '0;
   assign init_done_o = ~rst_i;
`endif

   // prio_q=1 means p1 wins the next tie
   assign g0 = active & p0_req_i & (~p1_req_i | ~prio_q);
   assign g1 = active & p1_req_i & ~g0;
   assign p0_gnt_o = g0;
   assign p1_gnt_o = g1;

   always_comb begin
      ram_en_o = g0 | g1 | init_wr;
      ram_we_o = 1'b0;
      ram_addr_o = '0;
      ram_wdata_o = INIT_VALUE;
      ram_be_o = '1;
      unique case (1'b1)
         init_wr: begin
            ram_we_o = 1'b1;
            ram_addr_o = init_addr;
         end
         g0: begin
            ram_we_o = p0_we_i;
            ram_addr_o = p0_addr_i;
            ram_wdata_o = p0_wdata_i;
            ram_be_o = p0_be_i;
         end
         g1: begin
            ram_we_o = p1_we_i;
            ram_addr_o = p1_addr_i;
            ram_wdata_o = p1_wdata_i;
            ram_be_o = p1_be_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      prio_d = prio_q;
      if (g0) prio_d = 1'b1;
      else if (g1) prio_d = 1'b0;
      rv0_d = g0;
      rv1_d = g1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
         rv0_q <= 1'b0;
         rv1_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
         rv0_q <= rv0_d;
         rv1_q <= rv1_d;
      end
   end

   assign p0_rvalid_o = rv0_q;
   assign p1_rvalid_o = rv1_q;
   assign p0_rdata_o = ram_rdata_i;
   assign p1_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural RAM attached.
// Covers SP_RAM_ARB_INIT_EN when that macro is defined.
module tb_sp_ram_arbiter;
`ifdef SP_RAM_ARB_INIT_EN
   localparam int AW = 4;
`else
   localparam int AW = 8;
`endif
   localparam int DW = 32;
   localparam int NB = 4;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic req;
      logic we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [NB-1:0] be;
   } rq_t;

   typedef struct packed {
      logic port;
      logic rd;
      logic [DW-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ld;
   logic p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic [NB-1:0] p0_be, p1_be;
   logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic [NB-1:0] ram_be;
   logic init_done;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] shadow [DEPTH];
   rsp_t sbq[$];
   logic prio;
   int checks = 0;
   int failures = 0;
   int gport;

   always #5 clk = ~clk;

   sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
      .p0_wdata_i(p0_wdata), .p0_be_i(p0_be), .p0_gnt_o(p0_gnt),
      .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
      .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
      .p1_wdata_i(p1_wdata), .p1_be_i(p1_be), .p1_gnt_o(p1_gnt),
      .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata),
      .init_done_o(init_done)
   );

   function automatic logic [DW-1:0] init_word(input int a);
      return {a[7:0] ^ 8'h5A, 8'hC3, ~a[7:0], a[7:0]};
   endfunction

   always @(posedge clk) begin
      if (ld) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      end else if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < NB; b++)
               if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic rq_t idle();
      return '0;
   endfunction

   function automatic rq_t rd(input int a);
      rq_t r = '0;
      r.req = 1'b1;
      r.addr = a[AW-1:0];
      return r;
   endfunction

   function automatic rq_t wr(input int a, input logic [DW-1:0] d,
                              input logic [NB-1:0] be);
      rq_t r = '0;
      r.req = 1'b1;
      r.we = 1'b1;
      r.addr = a[AW-1:0];
      r.wdata = d;
      r.be = be;
      return r;
   endfunction

   task automatic drive(input rq_t a, input rq_t b);
      p0_req = a.req; p0_we = a.we; p0_addr = a.addr;
      p0_wdata = a.wdata; p0_be = a.be;
      p1_req = b.req; p1_we = b.we; p1_addr = b.addr;
      p1_wdata = b.wdata; p1_be = b.be;
   endtask

   task automatic cycle(input rq_t a, input rq_t b);
      logic e0, e1;
      rsp_t e;
      rq_t g;
      @(posedge clk); #1;
      drive(a, b);
      @(negedge clk);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("rvalid0", p0_rvalid, !e.port);
         chk("rvalid1", p1_rvalid, e.port);
         if (e.rd) chk(e.port ? "rdata1" : "rdata0",
                       e.port ? p1_rdata : p0_rdata, e.data);
      end else begin
         chk("rv0_idle", p0_rvalid, 0);
         chk("rv1_idle", p1_rvalid, 0);
      end
      e0 = a.req & (!b.req | !prio);
      e1 = b.req & !e0;
      chk("gnt0", p0_gnt, e0);
      chk("gnt1", p1_gnt, e1);
      chk("ram_en", ram_en, e0 | e1);
      gport = e0 ? 0 : (e1 ? 1 : -1);
      if (e0 | e1) begin
         g = e0 ? a : b;
         chk("ram_we", ram_we, g.we);
         chk("ram_addr", ram_addr, g.addr);
         if (g.we) begin
            chk("ram_wdata", ram_wdata, g.wdata);
            chk("ram_be", ram_be, g.be);
            for (int i = 0; i < NB; i++)
               if (g.be[i]) shadow[g.addr][8*i +: 8] = g.wdata[8*i +: 8];
         end
         e.port = e1;
         e.rd = !g.we;
         e.data = shadow[g.addr];
         sbq.push_back(e);
         prio = e0;
      end else begin
         chk("ram_we_idle", ram_we, 0);
      end
   endtask

   task automatic reset_raw();
      @(posedge clk); #1;
      rst = 1'b1;
      drive(idle(), idle());
      @(negedge clk);
      chk("rst_rv0", p0_rvalid, 0);
      chk("rst_rv1", p1_rvalid, 0);
      chk("rst_gnt0", p0_gnt, 0);
      chk("rst_gnt1", p1_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_done", init_done, 0);
      sbq.delete();
      prio = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
`ifndef SP_RAM_ARB_INIT_EN
      #1 chk("done_after_rst", init_done, 1);
`endif
   endtask

`ifdef SP_RAM_ARB_INIT_EN
   task automatic init_run(input int lim);
      bit done = 0;
      for (int k = 1; k <= 40 && !done; k++) begin
         if (lim != 0 && k > lim) return;
         @(posedge clk); #1;
         if (k < 16) drive(rd(1), rd(2));
         else drive(idle(), idle());
         @(negedge clk);
         chk("init_rv0", p0_rvalid, 0);
         chk("init_rv1", p1_rvalid, 0);
         if (init_done) begin
            chk("init_len", k, 16);
            done = 1;
         end else begin
            chk("init_gnt0", p0_gnt, 0);
            chk("init_gnt1", p1_gnt, 0);
            chk("init_en", ram_en, 1);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, k % DEPTH);
            chk("init_be", ram_be, 4'hF);
            chk("init_wdata", ram_wdata, 0);
         end
      end
      if (lim == 0) begin
         if (!done) chk("init_timeout", 0, 1);
         for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      end
   endtask
`endif

   task automatic do_reset();
      reset_raw();
`ifdef SP_RAM_ARB_INIT_EN
      init_run(0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] old, exp;
      rq_t ra, rb;
      ld = 1'b1;
      drive(idle(), idle());
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      prio = 1'b0;
      @(posedge clk); #1;
      ld = 1'b0;
`ifdef SP_RAM_ARB_INIT_EN
      reset_raw();
      init_run(5);
`endif
      do_reset();
`ifdef SP_RAM_ARB_INIT_EN
      for (int i = 0; i < DEPTH; i++) cycle(rd(i), idle());
      cycle(idle(), idle());
`endif

      old = shadow[8'h10 % DEPTH];
      cycle(rd(8'h10), idle());
      chk("rd10_port", gport, 0);
      cycle(idle(), idle());
      chk("rd10_data", p0_rdata, old);

      old = shadow[8'h20 % DEPTH];
      exp = {old[31:24], 8'hAD, old[15:8], 8'hEF};
      cycle(wr(8'h20, 32'hDEADBEEF, 4'b0101), idle());
      cycle(idle(), rd(8'h20));
      chk("wr_ack_port", gport, 1);
      cycle(idle(), idle());
      chk("rmw_data", p1_rdata, exp);

      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(rd(i), rd(i + 8'h40));
         chk("alt_port", gport, i % 2);
      end
      cycle(idle(), idle());

      for (int i = 0; i < 3; i++) begin
         cycle(idle(), wr(i + 3, 32'h1234_5678 + i, 4'hF));
         chk("p1_only", gport, 1);
      end
      cycle(rd(3), rd(4));
      chk("tie_after_p1", gport, 0);
      cycle(rd(5), rd(4));
      chk("tie_next", gport, 1);
      cycle(idle(), idle());

      cycle(rd(6), idle());
      chk("pre_rst_port", gport, 0);
      do_reset();
      cycle(rd(7), rd(8));
      chk("post_rst_tie", gport, 0);
      cycle(idle(), idle());

      for (int n = 0; n < 300; n++) begin
         ra = '0;
         rb = '0;
         ra.req = $urandom_range(0, 1);
         ra.we = $urandom_range(0, 1);
         ra.addr = AW'($urandom_range(0, 15));
         ra.wdata = $urandom;
         ra.be = NB'($urandom_range(0, 15));
         rb.req = $urandom_range(0, 1);
         rb.we = $urandom_range(0, 1);
         rb.addr = AW'($urandom_range(0, 15));
         rb.wdata = $urandom;
         rb.be = NB'($urandom_range(0, 15));
         cycle(ra, rb);
      end
      cycle(idle(), idle());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
